event_write_arbiter: RTL
========================

# event_write_arbiter

Shares the single write port of the keyboard event FIFO among several event requesters (keys/encoders, patient buttons, diagnostics) and sequences the FIFO-clear plus CPLD-version-injection procedure. It sits between the event sources and the `Fifo` instance, on the SPI clock domain. It replaces ad-hoc muxing of write strobes. Each requester gets one latched pending slot, grants are round-robin, and drops are reported as overflow.

## Interface
- `EVENT_W`, 8: event code width.
- `N_REQ`, 4: number of requesters, 2..8.
- `VERSION_CODE`, 8'h01: code written after a FIFO clear.
- `INJECT_VER`, 1: 1 = write `VERSION_CODE` after clear; 0 = skip.

- `clk` in 1: SPI clock (SCK); all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset (EXT).
- `req_valid` in N_REQ: per-requester one-cycle event strobe.
- `req_code` in N_REQ*EVENT_W: codes; requester i at bits [i*EVENT_W +: EVENT_W].
- `clr_cmd` in 1: one-cycle request to clear the FIFO (from decoded SPI command).
- `fifo_full` in 1: FIFO cannot accept a write this cycle.
- `ovf_clr` in 1: clears all overflow flags.
- `fifo_wr` out 1: registered write strobe to FIFO.
- `fifo_data` out EVENT_W: registered write data.
- `fifo_clr` out 1: registered synchronous clear to FIFO.
- `pending` out N_REQ: per-requester slot occupied.
- `ovf` out N_REQ: sticky per-requester dropped-event flag.
- `busy` out 1: high while in CLR or VER state.

## Operation
- Reset: every output is 0. This covers `fifo_wr`, `fifo_data`, `fifo_clr`, `pending`, `ovf` and `busy`. State = RUN and round-robin pointer = 0. Reset asserted mid-operation aborts any sequence immediately. Latched codes are discarded.
- Pending slots:
  - `req_valid[i]` with `pending[i]`=0: latch the code and set `pending[i]`.
  - `req_valid[i]` with `pending[i]`=1 and slot i not granted this cycle: keep the old code and set `ovf[i]`.
  - `req_valid[i]` in the same cycle slot i is granted: latch the new code, `pending[i]` stays 1, no overflow.
- RUN state, when any `pending` bit is set and `fifo_full`=0:
  - Search starts at the pointer, ascending modulo N_REQ.
  - The first pending index g wins.
  - Next edge: `fifo_wr`=1, `fifo_data`=code[g], `pending[g]` cleared, pointer = (g+1) mod N_REQ.
  - At most one write per cycle.
  - `fifo_full`=1: no grant, `fifo_wr`=0, pointer unchanged.
- `clr_cmd` in RUN goes to CLR. `clr_cmd` in CLR or VER is ignored.
- CLR state (1 cycle):
  - `fifo_clr`=1, `busy`=1, `fifo_wr`=0.
  - All pending bits are cleared at the CLR exit edge.
  - `req_valid` during CLR is discarded without setting `ovf`.
  - Next state is VER if `INJECT_VER`, else RUN.
- VER state (1 cycle):
  - `fifo_wr`=1, `fifo_data`=`VERSION_CODE`, `busy`=1.
  - `fifo_full` is ignored because the FIFO was just cleared.
  - `req_valid` during VER is latched normally.
  - Next state is RUN; the pointer is reset to 0.
- `ovf_clr` clears all `ovf` bits. A set event for bit i in the same cycle wins over the clear.
- `fifo_data` holds its last value when `fifo_wr`=0.

## Timing
- `req_valid` sampled at edge k sets `pending` at k. The earliest matching `fifo_wr` is high in cycle k+1 → k+2, giving 2-edge latency.
- `clr_cmd` at edge k:
  - `fifo_clr` high for exactly one cycle, after edge k+1.
  - VER write after edge k+2.
  - RUN writes resume after edge k+3 at the earliest.
- `fifo_wr` and `fifo_clr` are never high in the same cycle.
- `fifo_full` is sampled in the same cycle the grant is decided (RUN only).
- Steady-state throughput is one write per clock while `fifo_full`=0.

## Test plan
- Reset check: assert `rst` mid-grant with `pending`=4'b1011 → all outputs 0 immediately; after release, no write occurs without a new `req_valid`.
- Round-robin fairness: pulse `req_valid`=4'b1111 with codes 8'h10/8'h21/8'h32/8'h43 (requester 0..3) → writes 10, 21, 32, 43 on consecutive cycles. Repeat with pointer=2 → 32, 43, 10, 21.
- Backpressure and overflow:
  - Hold `fifo_full`=1 for 5 cycles with pending[1] holding 8'h21; pulse requester 1 again with 8'h55 → no writes, `ovf`=4'b0010.
  - Release `fifo_full` → a single write of 21.
  - `ovf_clr` → `ovf`=0.
- Same-cycle refill: requester 2 granted in the same cycle as a new `req_valid[2]` with 8'h77 → write 8'h32, then a later write of 8'h77, `ovf[2]`=0.
- Clear sequence:
  - `clr_cmd` while `pending`=4'b0110 → one-cycle `fifo_clr`, then `fifo_wr` with 8'h01, `pending`=0.
  - `req_valid[0]` during CLR is dropped with no `ovf`.
  - `req_valid[0]` during VER is written after the version code.
- No injection: with `INJECT_VER`=0, `clr_cmd` → `fifo_clr` pulse only and `busy` high for 1 cycle. A second `clr_cmd` during CLR has no effect.

Source files
------------

// File: rtl/event_write_arbiter.sv
// Round-robin arbiter sharing the event FIFO write port among N_REQ requesters,
// with a one-slot pending latch per requester and a FIFO clear / version-inject sequence.
module event_write_arbiter #(
    parameter int unsigned        EVENT_W      = 8,
    parameter int unsigned        N_REQ        = 4,
    parameter logic [EVENT_W-1:0] VERSION_CODE = EVENT_W'('h01),
    parameter bit                 INJECT_VER   = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*EVENT_W-1:0] i_req_code,
    input  logic                     i_clr_cmd,
    input  logic                     i_fifo_full,
    input  logic                     i_ovf_clr,
    output logic                     o_fifo_wr,
    output logic [EVENT_W-1:0]       o_fifo_data,
    output logic                     o_fifo_clr,
    output logic [N_REQ-1:0]         o_pending,
    output logic [N_REQ-1:0]         o_ovf,
    output logic                     o_busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_CLR = 2'd1,
        S_VER = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [N_REQ-1:0]   r_pending;
    logic [N_REQ-1:0]   w_pending_nxt;
    logic [N_REQ-1:0]   r_ovf;
    logic [N_REQ-1:0]   w_ovf_nxt;
    logic [EVENT_W-1:0] r_code     [N_REQ];
    logic [EVENT_W-1:0] w_code_nxt [N_REQ];
    logic               r_fifo_wr;
    logic               w_fifo_wr_nxt;
    logic [EVENT_W-1:0] r_fifo_data;
    logic [EVENT_W-1:0] w_fifo_data_nxt;
    logic               r_fifo_clr;
    logic               w_fifo_clr_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    logic [PTR_W-1:0]   w_rot_idx [N_REQ];
    logic               w_grant_vld;
    logic [PTR_W-1:0]   w_grant_idx;

    // Requester index visited at search step k: (ptr + k) mod N_REQ
    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (32'(r_ptr) + 32'(k) >= N_REQ) begin
                w_rot_idx[k] = PTR_W'(32'(r_ptr) + 32'(k) - N_REQ);
            end else begin
                w_rot_idx[k] = PTR_W'(32'(r_ptr) + 32'(k));
            end
        end
    end

    // Descending scan so the pending slot closest to the pointer wins
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (r_state == S_RUN && !i_fifo_full) begin
            for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
                if (r_pending[w_rot_idx[k]]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_rot_idx[k];
                end
            end
        end
    end

    // Next state and busy flag
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN:   if (i_clr_cmd) w_state_nxt = S_CLR;
            S_CLR:   w_state_nxt = INJECT_VER ? S_VER : S_RUN;
            S_VER:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
        w_busy_nxt = (w_state_nxt != S_RUN);
    end

    // Pending slots, overflow flags, pointer and FIFO-side outputs
    always_comb begin
        w_pending_nxt   = r_pending;
        w_code_nxt      = r_code;
        w_ovf_nxt       = r_ovf & ~{N_REQ{i_ovf_clr}};
        w_ptr_nxt       = r_ptr;
        w_fifo_wr_nxt   = 1'b0;
        w_fifo_data_nxt = r_fifo_data;
        w_fifo_clr_nxt  = 1'b0;

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_state == S_CLR) begin
                w_pending_nxt[i] = 1'b0;
            end else if (i_req_valid[i]) begin
                // A slot being granted this cycle frees up and may be refilled at once
                if (!r_pending[i] || (w_grant_vld && 32'(w_grant_idx) == i)) begin
                    w_code_nxt[i]    = i_req_code[i*EVENT_W +: EVENT_W];
                    w_pending_nxt[i] = 1'b1;
                end else begin
                    w_ovf_nxt[i] = 1'b1;
                end
            end else if (w_grant_vld && 32'(w_grant_idx) == i) begin
                w_pending_nxt[i] = 1'b0;
            end
        end

        if (w_grant_vld) begin
            w_fifo_wr_nxt   = 1'b1;
            w_fifo_data_nxt = r_code[w_grant_idx];
            if (32'(w_grant_idx) + 32'd1 >= N_REQ) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = PTR_W'(32'(w_grant_idx) + 32'd1);
            end
        end

        // FIFO was just cleared, so the version write ignores fifo_full
        if (r_state == S_VER) begin
            w_fifo_wr_nxt   = 1'b1;
            w_fifo_data_nxt = VERSION_CODE;
            w_ptr_nxt       = '0;
        end

        if (r_state == S_CLR) begin
            w_fifo_clr_nxt = 1'b1;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_pending   <= '0;
            r_ovf       <= '0;
            r_fifo_wr   <= 1'b0;
            r_fifo_data <= '0;
            r_fifo_clr  <= 1'b0;
            r_busy      <= 1'b0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                r_code[i] <= '0;
            end
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_pending   <= w_pending_nxt;
            r_ovf       <= w_ovf_nxt;
            r_fifo_wr   <= w_fifo_wr_nxt;
            r_fifo_data <= w_fifo_data_nxt;
            r_fifo_clr  <= w_fifo_clr_nxt;
            r_busy      <= w_busy_nxt;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                r_code[i] <= w_code_nxt[i];
            end
        end
    end

    assign o_fifo_wr   = r_fifo_wr;
    assign o_fifo_data = r_fifo_data;
    assign o_fifo_clr  = r_fifo_clr;
    assign o_pending   = r_pending;
    assign o_ovf       = r_ovf;
    assign o_busy      = r_busy;

endmodule
